// File: rtl/is_uart_rx_buffer.sv
// Receive frame buffer behind the UART RX FSM: edge-detects the frame strobe, stores
// {ferr, data} in a first-word-fall-through FIFO and keeps sticky overrun / framing-error status.
module is_uart_rx_buffer #(
    parameter int DEPTH      = 8,
    parameter int FERR_CNT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_data_en_i,
    input  logic [9:0]                   rx_data_t_i,
    input  logic                         rd_en_i,
    input  logic                         flush_i,
    input  logic                         clr_i,
    output logic                         m_valid_o,
    output logic [7:0]                   m_data_o,
    output logic                         m_ferr_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overrun_o,
    output logic [FERR_CNT_W-1:0]        ferr_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [FERR_CNT_W-1:0] CNT_ONE  = FERR_CNT_W'(1);
    localparam logic [FERR_CNT_W-1:0] CNT_MAX  = '1;

    logic [8:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  en_d_q;
    logic                  rst_mask_q;
    logic                  overrun_q, overrun_d;
    logic [FERR_CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;

    logic wr_req, rd_acc, full, wr_acc, drop;
    logic unused_parity;

    assign unused_parity = rx_data_t_i[8];

    // One write per strobe; the mask stops a strobe held across reset release from writing.
    assign wr_req = rx_data_en_i & ~en_d_q & ~rst_mask_q;
    assign full   = (level_q == LVL_FULL);
    assign rd_acc = rd_en_i & (level_q != '0);
    assign wr_acc = wr_req & ~flush_i & (~full | rd_acc);
    assign drop   = wr_req & ~flush_i & full & ~rd_acc;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        ferr_cnt_d = ferr_cnt_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_acc && !rd_acc)      level_d = level_q + LVL_ONE;
            else if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
        end

        if (drop) overrun_d = 1'b1;
        if (wr_acc && rx_data_t_i[9] && (ferr_cnt_q != CNT_MAX)) ferr_cnt_d = ferr_cnt_q + CNT_ONE;

        if (clr_i) begin
            overrun_d  = 1'b0;
            ferr_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            en_d_q     <= 1'b0;
            rst_mask_q <= 1'b1;
            overrun_q  <= 1'b0;
            ferr_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            en_d_q     <= rx_data_en_i;
            rst_mask_q <= 1'b0;
            overrun_q  <= overrun_d;
            ferr_cnt_q <= ferr_cnt_d;
        end
    end

    // NOTE: storage is not reset; only the pointers and level qualify its contents.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= {rx_data_t_i[9], rx_data_t_i[7:0]};
    end

    // Head is forced to zero while empty so stale storage never reaches the host.
    assign m_valid_o  = (level_q != '0);
    assign m_data_o   = m_valid_o ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign m_ferr_o   = m_valid_o ? mem_q[rd_ptr_q][8]   : 1'b0;
    assign level_o    = level_q;
    assign full_o     = full;
    assign empty_o    = (level_q == '0);
    assign overrun_o  = overrun_q;
    assign ferr_cnt_o = ferr_cnt_q;

endmodule

// File: tb/tb_is_uart_rx_buffer.sv
// Randomized bench for is_uart_rx_buffer, checked every cycle against a queue-based model.
module tb_is_uart_rx_buffer;

    localparam int DEPTH   = 8;
    localparam int CNT_MAX = 255;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_data_en_i = 1'b0;
    logic [9:0] rx_data_t_i = '0;
    logic       rd_en_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       m_valid_o;
    logic [7:0] m_data_o;
    logic       m_ferr_o;
    logic [3:0] level_o;
    logic       full_o;
    logic       empty_o;
    logic       overrun_o;
    logic [7:0] ferr_cnt_o;

    is_uart_rx_buffer #(.DEPTH(DEPTH), .FERR_CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_en_i(rx_data_en_i), .rx_data_t_i(rx_data_t_i),
        .rd_en_i(rd_en_i), .flush_i(flush_i), .clr_i(clr_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ferr_o(m_ferr_o),
        .level_o(level_o), .full_o(full_o), .empty_o(empty_o),
        .overrun_o(overrun_o), .ferr_cnt_o(ferr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: FIFO contents, sticky status and strobe history.
    logic [8:0] m_q [$];
    bit         m_overrun;
    int         m_cnt;
    bit         m_prev_en;
    bit         m_first_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_overrun    = 0;
        m_cnt        = 0;
        m_prev_en    = 0;
        m_first_edge = 1;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(m_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("data", 32'(m_data_o), 32'(m_q[0][7:0]));
            chk("ferr", 32'(m_ferr_o), 32'(m_q[0][8]));
        end
        chk("level", 32'(level_o), 32'(m_q.size()));
        chk("full", 32'(full_o), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty_o), 32'(m_q.size() == 0));
        chk("overrun", 32'(overrun_o), 32'(m_overrun));
        chk("ferr_cnt", 32'(ferr_cnt_o), 32'(m_cnt));
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_data", 32'(m_data_o), 0);
        chk("rst_ferr", 32'(m_ferr_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_overrun", 32'(overrun_o), 0);
        chk("rst_cnt", 32'(ferr_cnt_o), 0);
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(input logic en, input logic [9:0] d, input logic rd,
                         input logic fl, input logic cl);
        bit wr, ra;
        rx_data_en_i = en; rx_data_t_i = d; rd_en_i = rd; flush_i = fl; clr_i = cl;
        wr = en && !m_prev_en && !m_first_edge;
        ra = rd && (m_q.size() != 0);
        if (fl) begin
            m_q.delete();
        end else begin
            if (wr && m_q.size() == DEPTH && !ra) begin
                m_overrun = 1;
            end else if (wr) begin
                if (d[9] && m_cnt < CNT_MAX) m_cnt++;
            end
            if (ra) void'(m_q.pop_front());
            if (wr && !(m_q.size() == DEPTH)) m_q.push_back({d[9], d[7:0]});
        end
        if (cl) begin
            m_overrun = 0;
            m_cnt     = 0;
        end
        m_prev_en    = en;
        m_first_edge = 0;
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    task automatic frame(input logic [9:0] d, input logic rd_rise, input logic rd_fall);
        cycle(1'b1, d, rd_rise, 1'b0, 1'b0);
        cycle(1'b0, d, rd_fall, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_values();
        #20 rst_i = 1'b1;
        idle(2);

        // 3-cycle strobe writes once; visible right after the rising edge.
        cycle(1'b1, 10'h0A5, 1'b0, 1'b0, 1'b0);
        chk("first_valid", 32'(m_valid_o), 1);
        chk("first_data", 32'(m_data_o), 32'h A5);
        cycle(1'b1, 10'h0A5, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'h0A5, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("one_write_level", 32'(level_o), 1);
        cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("pop_empty", 32'(empty_o), 1);
        cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);

        // Framing errors and saturation.
        frame(10'h23C, 1'b0, 1'b0);
        chk("ferr_head", 32'(m_ferr_o), 1);
        chk("ferr_cnt1", 32'(ferr_cnt_o), 1);
        cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) frame({1'b1, 1'($urandom), 8'($urandom)}, 1'b0, 1'b1);
        chk("ferr_sat", 32'(ferr_cnt_o), CNT_MAX);
        cycle(1'b0, 10'h0, 1'b0, 1'b0, 1'b1);
        chk("ferr_clr", 32'(ferr_cnt_o), 0);

        // Overfill: 9th frame dropped.
        for (int i = 0; i < 9; i++) frame(10'(i), 1'b0, 1'b0);
        chk("over_full", 32'(full_o), 1);
        chk("over_flag", 32'(overrun_o), 1);
        for (int i = 0; i < 8; i++) begin
            chk("over_order", 32'(m_data_o), 32'(i));
            cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("over_drained", 32'(empty_o), 1);
        cycle(1'b0, 10'h0, 1'b0, 1'b0, 1'b1);

        // Write and read together while full.
        for (int i = 0; i < 8; i++) frame(10'(8'h10 + i), 1'b0, 1'b0);
        frame(10'h05A, 1'b1, 1'b0);
        chk("full_rw_level", 32'(level_o), 8);
        chk("full_rw_ovr", 32'(overrun_o), 0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);
        chk("full_rw_last", 32'(m_data_o), 32'h5A);
        cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);

        // Random interleave; wraps pointers several times.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 10'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 10'h0, 1'b1, 1'b0, 1'b0);

        // Flush with a simultaneous write at level 5.
        for (int i = 0; i < 5; i++) frame(10'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 10'h0FF, 1'b0, 1'b1, 1'b0);
        chk("flush_level", 32'(level_o), 0);
        chk("flush_valid", 32'(m_valid_o), 0);
        idle(1);

        // Async reset mid-strobe, strobe held across release.
        frame(10'h011, 1'b0, 1'b0);
        cycle(1'b1, 10'h022, 1'b0, 1'b0, 1'b0);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 10'h033, 1'b0, 1'b0, 1'b0);
        chk("held_strobe", 32'(level_o), 0);
        cycle(1'b0, 10'h033, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 10'h044, 1'b0, 1'b0, 1'b0);
        chk("post_rst_write", 32'(m_data_o), 32'h44);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
